// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// datapath mux selects and the per-state control word.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } mc_state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    // fetch marks the MemReady-qualified IRWrite/PCUpdate; decode gates the illegal-op pulse.
    typedef struct packed {
        logic        fetch;
        logic        decode;
        logic        pc_update;
        logic        branch;
        logic        adr_src;
        logic        mem_write;
        logic        reg_write;
        result_src_t result_src;
        src_a_t      alu_src_a;
        src_b_t      alu_src_b;
        alu_op_t     alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input mc_state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_DECODE: begin
                c.decode    = 1'b1;
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            default: begin
                c.fetch      = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
        endcase
        return c;
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic imm_src_t imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and status in, datapath controls out.
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic       IllegalOp;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, IllegalOp
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, IllegalOp
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Existing ALU decoder: maps ALUOp plus instruction fields onto the ALU operation code.
module alu_decoder (
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl
);

    logic rtype_sub;

    // Only R-type (op[5]=1) uses funct7b5 to select sub; addi ignores it.
    assign rtype_sub = funct7b5 & opb5;

    always_comb begin
        ALUControl = 3'b000;
        case (ALUOp)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = rtype_sub ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with MemReady stalls.
// Optional bne support through the BEQ state when MC_BNE_EN is defined.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    multicycle_controller_if.master   bus
);

    mc_state_t  state;
    mc_state_t  state_next;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl;
    logic       take_branch;
    logic       bad_branch;
    logic [2:0] alu_control;

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH:         state_next = S_BEQ;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = bus.MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = bus.MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BEQ:      state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // The control word is registered from the next state so it always matches state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            ctrl_q <= state_ctrl(S_FETCH);
        end else begin
            state  <= state_next;
            ctrl_q <= state_ctrl(state_next);
        end
    end

    // Reset overrides the registered word at once so an aborted access emits no strobe.
    always_comb begin
        ctrl = ctrl_q;
        if (reset) begin
            ctrl       = state_ctrl(S_FETCH);
            ctrl.fetch = 1'b0;
        end
    end

`ifdef MC_BNE_EN
    always_comb begin
        take_branch = 1'b0;
        bad_branch  = 1'b0;
        case (bus.funct3)
            3'b000:  take_branch = bus.Zero;
            3'b001:  take_branch = ~bus.Zero;
            default: bad_branch  = 1'b1;
        endcase
    end
`else
    always_comb begin
        take_branch = bus.Zero;
        bad_branch  = 1'b0;
    end
`endif

    alu_decoder u_alu_decoder (
        .opb5       (bus.op[5]),
        .funct3     (bus.funct3),
        .funct7b5   (bus.funct7b5),
        .ALUOp      (ctrl.alu_op),
        .ALUControl (alu_control)
    );

    assign bus.PCWrite    = (ctrl.fetch & bus.MemReady) | ctrl.pc_update
                          | (ctrl.branch & take_branch);
    assign bus.IRWrite    = ctrl.fetch & bus.MemReady;
    assign bus.AdrSrc     = ctrl.adr_src;
    assign bus.MemWrite   = ctrl.mem_write;
    assign bus.RegWrite   = ctrl.reg_write;
    assign bus.ResultSrc  = ctrl.result_src;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.ImmSrc     = imm_src_for(bus.op);
    assign bus.ALUControl = alu_control;
    assign bus.IllegalOp  = (ctrl.decode & ~op_supported(bus.op))
                          | (ctrl.branch & bad_branch);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; expected vectors are hand-derived per cycle.
// Vector field order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl RegWrite IllegalOp
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [16:0] observed();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.RegWrite,
                bus.IllegalOp};
    endfunction

    task automatic chk(input string tag, input logic [16:0] expected);
        logic [16:0] obs;
        obs = observed();
        checks++;
        assert (obs === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic zero, input logic mr);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = zero;
        bus.MemReady = mr;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        chk("reset_outputs",      17'b0_0_0_0_10_00_10_00_000_0_0);
        reset = 1'b0;
        #1;

        // add
        chk("add_fetch",          17'b1_0_0_1_10_00_10_00_000_0_0);
        tick();
        chk("add_decode",         17'b0_0_0_0_00_01_01_00_000_0_0);
        tick();
        chk("add_execr",          17'b0_0_0_0_00_10_00_00_000_0_0);
        tick();
        chk("add_aluwb",          17'b0_0_0_0_00_00_00_00_000_1_0);
        tick();

        // sub
        drive(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        chk("sub_execr",          17'b0_0_0_0_00_10_00_00_001_0_0);
        tick();
        tick();

        // addi with bit30 set stays add
        drive(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        chk("addi_execi",         17'b0_0_0_0_00_10_01_00_000_0_0);
        tick();
        chk("addi_aluwb",         17'b0_0_0_0_00_00_00_00_000_1_0);
        tick();

        // lw with fetch stall and two MEMREAD wait cycles
        drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("fetch_stall",        17'b0_0_0_0_10_00_10_00_000_0_0);
        tick();
        drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
        chk("lw_fetch",           17'b1_0_0_1_10_00_10_00_000_0_0);
        tick();
        chk("lw_decode",          17'b0_0_0_0_00_01_01_00_000_0_0);
        tick();
        chk("lw_memadr",          17'b0_0_0_0_00_10_01_00_000_0_0);
        tick();
        drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("lw_memread_wait1",   17'b0_1_0_0_00_00_00_00_000_0_0);
        tick();
        chk("lw_memread_wait2",   17'b0_1_0_0_00_00_00_00_000_0_0);
        tick();
        drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
        chk("lw_memread_done",    17'b0_1_0_0_00_00_00_00_000_0_0);
        tick();
        chk("lw_memwb",           17'b0_0_0_0_01_00_00_00_000_1_0);
        tick();

        // sw with one MEMWRITE wait cycle
        drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        chk("sw_fetch",           17'b1_0_0_1_10_00_10_01_000_0_0);
        tick();
        chk("sw_decode",          17'b0_0_0_0_00_01_01_01_000_0_0);
        tick();
        chk("sw_memadr",          17'b0_0_0_0_00_10_01_01_000_0_0);
        tick();
        drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("sw_memwrite_wait",   17'b0_1_1_0_00_00_00_01_000_0_0);
        tick();
        drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        chk("sw_memwrite_done",   17'b0_1_1_0_00_00_00_01_000_0_0);
        tick();

        // beq taken; FETCH here also shows MemWrite has dropped
        drive(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1);
        chk("beq_fetch_mw_low",   17'b1_0_0_1_10_00_10_10_000_0_0);
        tick();
        tick();
        chk("beq_taken",          17'b1_0_0_0_00_10_00_10_001_0_0);
        tick();

        drive(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk("beq_not_taken",      17'b0_0_0_0_00_10_00_10_001_0_0);
        tick();

`ifdef MC_BNE_EN
        drive(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk("bne_taken",          17'b1_0_0_0_00_10_00_10_001_0_0);
        tick();

        drive(7'b1100011, 3'b100, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        chk("branch_bad_funct3",  17'b0_0_0_0_00_10_00_10_001_0_1);
        tick();
`else
        drive(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        chk("branch_zero_only",   17'b1_0_0_0_00_10_00_10_001_0_0);
        tick();
`endif

        // jal
        drive(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk("jal_state",          17'b1_0_0_0_00_01_10_11_000_0_0);
        tick();
        chk("jal_aluwb",          17'b0_0_0_0_00_00_00_11_000_1_0);
        tick();

        // unsupported opcode (lui)
        drive(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        chk("illegal_decode",     17'b0_0_0_0_00_01_01_00_000_0_1);
        tick();
        chk("illegal_next_fetch", 17'b1_0_0_1_10_00_10_00_000_0_0);
        tick();
        tick();

        // reset during MEMWRITE wait (instruction above is again in FETCH after lui's DECODE)
        drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("rst_pre_memwrite",   17'b0_1_1_0_00_00_00_01_000_0_0);
        tick();
        reset = 1'b1;
        #1;
        chk("rst_in_memwrite",    17'b0_0_0_0_10_00_10_01_000_0_0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_fetch_stall",    17'b0_0_0_0_10_00_10_01_000_0_0);
        drive(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        chk("rst_fetch_ready",    17'b1_0_0_1_10_00_10_01_000_0_0);
        tick();
        chk("rst_then_decode",    17'b0_0_0_0_00_01_01_01_000_0_0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state sequencer for the multicycle RV32I core. It drives a shared datapath through fetch, decode, execute, memory and writeback steps: one ALU, a single unified instruction/data memory, and the IR/OldPC/ALUOut/Data registers. It also stalls on a memory ready handshake. It supports lw, sw, R-type, I-type ALU, beq and jal, and reuses the existing ALU decoder to generate ALUControl.

## Interface
Parameters:
- none; the opcode and state encodings are fixed and defined in the shared package.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock domain (clk), no async paths
- op  input  7  instruction opcode from IR
- funct3  input  3  instruction funct3 from IR
- funct7b5  input  1  IR bit 30
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes the current access this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  IR and OldPC enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  output  3  ALU operation
- RegWrite  output  1  register file write enable
- IllegalOp  output  1  one-cycle pulse on an unsupported opcode

## Operation
- Outputs are Moore-decoded from the state, except the MemReady-qualified strobes, PCWrite, and ImmSrc (combinational from op). Unlisted controls default to 0 and ALUOp to 00.
- PCWrite = PCUpdate | (Branch & Zero).
- States and behaviour:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=PCUpdate=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other op → FETCH with IllegalOp=1
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady; then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Then FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held through the wait. Goes to FETCH on MemReady.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Then ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Then FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Then ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Then FETCH.
- ALUOp 00 gives add, 01 gives sub, 10 decodes from funct3/funct7b5/op[5].
- Unused state encodings → FETCH.

## Timing
- Cycle counts with MemReady tied to 1:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq: 3
  - unsupported opcode: 2
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Reset:
  - While reset=1: PCWrite, IRWrite, RegWrite, MemWrite and IllegalOp are forced to 0. Mux selects show FETCH values (AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10).
  - The state is FETCH on the first edge after reset.
  - Reset mid-instruction, including during a MemReady wait, aborts the instruction; no strobe follows.
- MemWrite falls in the cycle after the MemReady=1 edge.

## Configuration
- MC_BNE_EN defined:
  - BEQ state also serves bne.
  - Branch is taken when funct3=000 and Zero=1, or funct3=001 and Zero=0.
  - Any other branch funct3 → no PC update and IllegalOp pulses in BEQ.
- MC_BNE_EN undefined:
  - Branch is taken on Zero alone, regardless of funct3.

## Structure
- Shared package `riscv_pkg`:
  - opcode localparams (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH)
  - state enum typedef mc_state_t
  - ALUOp, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings
- Sub-module: instantiate the existing alu_decoder (op[5], funct3, funct7b5, ALUOp → ALUControl). Do not duplicate its logic.

## Test plan
- add (op=0110011, funct3=000, funct7b5=0), MemReady=1 → states FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000 in EXECUTER; RegWrite=1 only in cycle 4.
- lw with MemReady=0 for 2 cycles in MEMREAD → 7 cycles total; AdrSrc=1 for all 3 MEMREAD cycles; ResultSrc=01 and RegWrite=1 in MEMWB.
- sw with MemReady=0 for 1 cycle in MEMWRITE → MemWrite=1 for exactly 2 cycles; RegWrite never asserted.
- beq with Zero=1 → PCWrite=1 in cycle 3. Repeat with Zero=0 → PCWrite=0. With MC_BNE_EN, funct3=001 and Zero=0 → PCWrite=1.
- op=0110111 → IllegalOp=1 in DECODE, FETCH next cycle, no RegWrite or MemWrite.
- reset asserted during the MEMWRITE wait → MemWrite=0 that cycle; FETCH next cycle with IRWrite following MemReady.
